// File: rtl/addr_sweep_checker_pkg.sv
// Shared constants, widths and state encoding for the adder sweep checker.
// Width helpers let the top derive vec/err widths from its own W parameter.
package addr_sweep_checker_pkg;

    localparam int unsigned W_DEF = 4;
    localparam int unsigned VEC_W = 2 * W_DEF;
    localparam int unsigned ERR_W = 2 * W_DEF + 1;
    localparam int unsigned NVEC  = 1 << VEC_W;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int unsigned vec_width(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned err_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/addr_sweep_checker_if.sv
// Control, adder-stimulus and result signals of the sweep checker.
// master = the checker, slave = the environment driving start and the adder sum.
interface addr_sweep_checker_if
    import addr_sweep_checker_pkg::*;
#(
    parameter int unsigned W = W_DEF
);

    logic                 start;
    logic [W-1:0]         adder_a;
    logic [W-1:0]         adder_b;
    logic [W:0]           adder_o;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*W:0]         err_cnt;
    logic [2*W-1:0]       first_fail_vec;
    logic                 first_fail_valid;

    modport master (
        input  start, adder_o,
        output adder_a, adder_b, busy, done, pass,
               err_cnt, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, adder_o,
        input  adder_a, adder_b, busy, done, pass,
               err_cnt, first_fail_vec, first_fail_valid
    );

endinterface

// File: rtl/addr_sweep_vecgen.sv
// Vector and settle-hold counters for the sweep; flags the sample cycle and
// the final vector. vec stops at all-ones and never wraps inside a sweep.
module addr_sweep_vecgen
    import addr_sweep_checker_pkg::*;
#(
    parameter int unsigned VW     = VEC_W,
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    output logic [VW-1:0] vec,
    output logic          last_vec_c,
    output logic          sample_now_c
);

    localparam int unsigned HOLD_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE - 1);
    localparam logic [VW-1:0]     VEC_LAST  = '1;

    logic [HOLD_W-1:0] hold;

    assign sample_now_c = run && (hold == HOLD_LAST);
    assign last_vec_c   = (vec == VEC_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec  <= '0;
            hold <= '0;
        end else if (sample_now_c) begin
            if (!last_vec_c) begin
                vec  <= vec + VW'(1);
                hold <= '0;
            end
        end else if (run) begin
            hold <= hold + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/addr_sweep_checker.sv
// Exhaustive (A,B) sweep of an external W-bit ripple adder against a golden
// A+B; counts mismatching vectors and captures the first failing {A,B}.
module addr_sweep_checker
    import addr_sweep_checker_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    addr_sweep_checker_if.master bus
);

    localparam int unsigned VW = vec_width(W);
    localparam int unsigned EW = err_width(W);

    state_t state, state_nx;

    logic [VW-1:0] vec;
    logic          last_vec_c;
    logic          sample_now_c;
    logic          vg_clear_c;
    logic          vg_run_c;
    logic [W:0]    golden_c;
    logic          mismatch_c;

    logic          busy_q, busy_nx;
    logic          done_q, done_nx;
    logic          pass_q, pass_nx;
    logic [EW-1:0] err_q, err_nx;
    logic [VW-1:0] ffvec_q, ffvec_nx;
    logic          ffv_q, ffv_nx;

    addr_sweep_vecgen #(
        .VW     (VW),
        .SETTLE (SETTLE)
    ) u_vecgen (
        .clk          (clk),
        .rst          (rst),
        .clear        (vg_clear_c),
        .run          (vg_run_c),
        .vec          (vec),
        .last_vec_c   (last_vec_c),
        .sample_now_c (sample_now_c)
    );

    // Golden sum at full W+1 bits from the operands currently on the adder
    assign golden_c   = (W+1)'(vec[VW-1:W]) + (W+1)'(vec[W-1:0]);
    assign mismatch_c = (bus.adder_o != golden_c);

    assign bus.adder_a          = vec[VW-1:W];
    assign bus.adder_b          = vec[W-1:0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_cnt          = err_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_valid = ffv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy_nx    = busy_q;
        done_nx    = done_q;
        pass_nx    = pass_q;
        err_nx     = err_q;
        ffvec_nx   = ffvec_q;
        ffv_nx     = ffv_q;
        vg_clear_c = 1'b0;
        vg_run_c   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx   = RUN;
                    vg_clear_c = 1'b1;
                    busy_nx    = 1'b1;
                    done_nx    = 1'b0;
                    pass_nx    = 1'b0;
                    err_nx     = '0;
                    ffvec_nx   = '0;
                    ffv_nx     = 1'b0;
                end
            end
            RUN: begin
                vg_run_c = 1'b1;
                if (sample_now_c) begin
                    if (mismatch_c) begin
                        err_nx = err_q + EW'(1);
                        if (!ffv_q) begin
                            ffvec_nx = vec;
                            ffv_nx   = 1'b1;
                        end
                    end
                    if (last_vec_c) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (err_nx == '0);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b0;
                pass_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
        end else begin
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            pass_q  <= pass_nx;
            err_q   <= err_nx;
            ffvec_q <= ffvec_nx;
            ffv_q   <= ffv_nx;
        end
    end

endmodule

// File: tb/tb_addr_sweep_checker.sv
// Bench for addr_sweep_checker: fault-injected behavioural adder (SETTLE=1)
// and a 2-cycle pipelined adder (SETTLE=3).
module tb_addr_sweep_checker;

    import addr_sweep_checker_pkg::*;

    typedef struct {
        int       mode;
        int       err;
        bit       ffv;
        int       ffvec;
        bit       pass;
    } exp_t;

    logic clk;
    logic rst;
    int   mode;
    int   total;
    int   bad;
    exp_t tbl [5];
    exp_t cur_exp;
    exp_t sb [$];
    logic [4:0] d1, d2;

    addr_sweep_checker_if #(.W(4)) bus1 ();
    addr_sweep_checker_if #(.W(4)) bus2 ();

    addr_sweep_checker #(.W(4), .SETTLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    addr_sweep_checker #(.W(4), .SETTLE(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder with selectable injected faults
    function automatic logic [4:0] model_adder(input logic [3:0] a, input logic [3:0] b, input int m);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            1: s[0] = 1'b0;
            2: s[4] = 1'b1;
            3: if (a == 4'hF && b == 4'hF) s[0] = ~s[0];
            4: if (a == 4'h0 && b == 4'h0) s[1] = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    always_comb bus1.adder_o = model_adder(bus1.adder_a, bus1.adder_b, mode);

    always @(posedge clk) begin
        d1 <= {1'b0, bus2.adder_a} + {1'b0, bus2.adder_b};
        d2 <= d1;
    end
    assign bus2.adder_o = d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_result();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty act=0 exp=1");
        end else begin
            e = sb.pop_front();
            chk("err_cnt", 32'(bus1.err_cnt), 32'(e.err));
            chk("ffv", 32'(bus1.first_fail_valid), 32'(e.ffv));
            chk("ffvec", 32'(bus1.first_fail_vec), 32'(e.ffvec));
            chk("pass", 32'(bus1.pass), 32'(e.pass));
            chk("busy_done", 32'(bus1.busy), 32'd0);
            chk("a_last", 32'(bus1.adder_a), 32'hF);
            chk("b_last", 32'(bus1.adder_b), 32'hF);
        end
    endtask

    task automatic run_sweep(input int restart_at, input int rst_at, input bit expect_done);
        int cyc;
        int limit;
        limit = expect_done ? 1000 : 400;
        @(negedge clk);
        bus1.start = 1'b1;
        if (expect_done) sb.push_back(cur_exp);
        @(negedge clk);
        bus1.start = 1'b0;
        chk("busy_start", 32'(bus1.busy), 32'd1);
        chk("done_clr", 32'(bus1.done), 32'd0);
        chk("pass_clr", 32'(bus1.pass), 32'd0);
        chk("err_clr", 32'(bus1.err_cnt), 32'd0);
        chk("ffv_clr", 32'(bus1.first_fail_valid), 32'd0);
        chk("a_vec0", 32'(bus1.adder_a), 32'd0);
        chk("b_vec0", 32'(bus1.adder_b), 32'd0);
        cyc = 0;
        while (!bus1.done && cyc < limit) begin
            bus1.start = (cyc == restart_at);
            rst        = (cyc == rst_at);
            @(negedge clk);
            cyc++;
            if (cyc == 1 && rst_at != 0) chk("b_vec1", 32'(bus1.adder_b), 32'd1);
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                chk("rst_busy", 32'(bus1.busy), 32'd0);
                chk("rst_done", 32'(bus1.done), 32'd0);
                chk("rst_err", 32'(bus1.err_cnt), 32'd0);
                chk("rst_ffv", 32'(bus1.first_fail_valid), 32'd0);
                chk("rst_a", 32'(bus1.adder_a), 32'd0);
                chk("rst_b", 32'(bus1.adder_b), 32'd0);
            end
        end
        bus1.start = 1'b0;
        rst        = 1'b0;
        if (expect_done) begin
            chk("done_latency", 32'(cyc), 32'(NVEC));
            check_result();
        end else begin
            chk("no_done", 32'(bus1.done), 32'd0);
            chk("idle_busy", 32'(bus1.busy), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        mode  = 0;
        rst   = 1'b1;
        bus1.start = 1'b0;
        bus2.start = 1'b0;

        tbl[0] = '{mode: 0, err: 0,   ffv: 1'b0, ffvec: 8'h00, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 128, ffv: 1'b1, ffvec: 8'h01, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 136, ffv: 1'b1, ffvec: 8'h00, pass: 1'b0};
        tbl[3] = '{mode: 3, err: 1,   ffv: 1'b1, ffvec: 8'hFF, pass: 1'b0};
        tbl[4] = '{mode: 4, err: 1,   ffv: 1'b1, ffvec: 8'h00, pass: 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus1.busy), 32'd0);
        chk("reset_done", 32'(bus1.done), 32'd0);
        chk("reset_pass", 32'(bus1.pass), 32'd0);
        chk("reset_err", 32'(bus1.err_cnt), 32'd0);
        chk("reset_ffv", 32'(bus1.first_fail_valid), 32'd0);
        chk("reset_ffvec", 32'(bus1.first_fail_vec), 32'd0);
        chk("reset_a", 32'(bus1.adder_a), 32'd0);
        chk("reset_b", 32'(bus1.adder_b), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mode    = tbl[i].mode;
            cur_exp = tbl[i];
            run_sweep(-1, -1, 1'b1);
        end

        // Start while busy is ignored, then a restart from DONE repeats the result
        mode    = 1;
        cur_exp = tbl[1];
        run_sweep(50, -1, 1'b1);
        run_sweep(-1, -1, 1'b1);

        // Reset mid-sweep aborts; the next sweep is unaffected
        run_sweep(-1, 100, 1'b0);
        run_sweep(-1, -1, 1'b1);

        // Pipelined adder with SETTLE=3
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        chk("s3_busy", 32'(bus2.busy), 32'd1);
        cyc = 0;
        while (!bus2.done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) chk("s3_b_hold", 32'(bus2.adder_b), 32'd0);
            if (cyc == 3) chk("s3_b_next", 32'(bus2.adder_b), 32'd1);
        end
        chk("s3_latency", 32'(cyc), 32'd768);
        chk("s3_err", 32'(bus2.err_cnt), 32'd0);
        chk("s3_pass", 32'(bus2.pass), 32'd1);
        chk("s3_ffv", 32'(bus2.first_fail_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
